dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/mips_pkg.sv | 14 +
 rtl/dmem_array.sv | 33 +++
 rtl/dmem_responder.sv | 166 ++++++++++++++++
 tb/tb_dmem_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and defaults for the data-memory responder.
package mips_pkg;

  localparam int WORD_W              = 32;
  localparam int DEPTH_DEFAULT       = 64;
  localparam int WAIT_CYCLES_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data memory: synchronous write, asynchronous read,
// asynchronous clear of every word on reset.
import mips_pkg::*;

module dmem_array #(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic [WORD_W-1:0] word0
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];
  assign word0 = mem[0];

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder for the pipeline memory stage.
// Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN.
import mips_pkg::*;

module dmem_responder #(
  parameter int DEPTH       = DEPTH_DEFAULT,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Req,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD,
  output logic        Ack,
  output logic        Stall,
  output logic        Err,
  output logic [15:0] test_value
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;
  logic accept, enter_resp;

  logic [IDX_W-1:0]  lat_idx;
  logic [WORD_W-1:0] lat_wd;
  logic              lat_we;

  logic [IDX_W-1:0]  cur_idx;
  logic [WORD_W-1:0] cur_wd;
  logic              cur_we;
  logic              misalign;

  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;
  logic [WORD_W-1:0] word0;
  logic              unused_bits;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (Req) begin
          accept = 1'b1;
          if (NO_WAIT) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign Stall = ((state == IDLE) && Req) || (state == WAIT);
  assign Ack   = (state == RESP);

  // With zero wait states the accepting edge is also the completing edge,
  // so the access must be served straight from the inputs in IDLE.
  always_comb begin
    cur_idx = lat_idx;
    cur_wd  = lat_wd;
    cur_we  = lat_we;
    if (state == IDLE) begin
      cur_idx = A[IDX_W+1:2];
      cur_wd  = WD;
      cur_we  = WE;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic [1:0] lat_off;
  logic [1:0] cur_off;
  logic       err_q;

  assign cur_off  = (state == IDLE) ? A[1:0] : lat_off;
  assign misalign = (cur_off != 2'b00);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lat_off <= 2'b00;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        lat_off <= A[1:0];
      end
      err_q <= enter_resp && misalign;
    end
  end

  assign Err = err_q;
`else
  assign misalign = 1'b0;
  assign Err      = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lat_idx <= '0;
      lat_wd  <= '0;
      lat_we  <= 1'b0;
    end else if (accept) begin
      lat_idx <= A[IDX_W+1:2];
      lat_wd  <= WD;
      lat_we  <= WE;
    end
  end

  // A trapped misaligned load returns zero rather than the array word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RD <= '0;
    end else if (enter_resp && !cur_we) begin
      RD <= misalign ? '0 : mem_rdata;
    end
  end

  assign mem_we = enter_resp && cur_we && !misalign;

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (CLK),
    .rst   (RST),
    .we    (mem_we),
    .addr  (cur_idx),
    .wdata (cur_wd),
    .rdata (mem_rdata),
    .word0 (word0)
  );

  assign test_value  = word0[15:0];
  assign unused_bits = ^{A[31:IDX_W+2], A[1:0], word0[31:16]};

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: WAIT_CYCLES=2 instance driven from a
// vector table plus hand sequences, and a WAIT_CYCLES=0 instance.
module tb_dmem_responder;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [31:0] a, wd, rd;
  logic        ack, stall, err;
  logic [15:0] tv;

  logic        req0, we0;
  logic [31:0] a0, wd0, rd0;
  logic        ack0, stall0, err0;
  logic [15:0] tv0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
    .CLK(clk), .RST(rst), .Req(req), .A(a), .WD(wd), .WE(we),
    .RD(rd), .Ack(ack), .Stall(stall), .Err(err), .test_value(tv)
  );

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .CLK(clk), .RST(rst), .Req(req0), .A(a0), .WD(wd0), .WE(we0),
    .RD(rd0), .Ack(ack0), .Stall(stall0), .Err(err0), .test_value(tv0)
  );

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [15:0] exp_tv;
  } vec_t;

  vec_t vecs [12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs one access on the WAIT_CYCLES=2 instance; inputs are scrambled
  // during WAIT so only the latched request can produce the right answer.
  task automatic applyStimulus(input vec_t v, input string tag);
    int lat;
    int stalls;
    bit got;
    @(negedge clk);
    req = 1'b1; we = v.we; a = v.a; wd = v.wd;
    #1;
    checkOutput({tag, "/stall_accept"}, {31'b0, stall}, 32'd1);
    stalls = 1; lat = 0; got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req = 1'b0; wd = ~v.wd; a = v.a ^ 32'h4; we = ~v.we;
      end
      #1;
      if (ack) begin
        got = 1'b1;
        lat = k;
        checkOutput({tag, "/rd"}, rd, v.exp_rd);
        checkOutput({tag, "/err"}, {31'b0, err}, {31'b0, v.exp_err});
        checkOutput({tag, "/test_value"}, {16'b0, tv}, {16'b0, v.exp_tv});
        checkOutput({tag, "/stall_resp"}, {31'b0, stall}, 32'd0);
      end else if (stall) begin
        stalls++;
      end
    end
    checkOutput({tag, "/latency"}, lat, 32'd3);
    checkOutput({tag, "/stall_cycles"}, stalls, 32'd3);
    @(negedge clk);
    #1;
    checkOutput({tag, "/ack_single"}, {31'b0, ack}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    int acks;
    logic [31:0] prev_rd;

    prev_rd = TRAP ? 32'h0 : 32'hCAFEF00D;
    vecs[0]  = '{1'b1, 32'h008, 32'hDEADBEEF, 32'h0,        1'b0, 16'h0};
    vecs[1]  = '{1'b0, 32'h008, 32'h0,        32'hDEADBEEF, 1'b0, 16'h0};
    vecs[2]  = '{1'b1, 32'h100, 32'h00001234, 32'hDEADBEEF, 1'b0, 16'h1234};
    vecs[3]  = '{1'b0, 32'h000, 32'h0,        32'h00001234, 1'b0, 16'h1234};
    vecs[4]  = '{1'b1, 32'h0FC, 32'hA5A5A5A5, 32'h00001234, 1'b0, 16'h1234};
    vecs[5]  = '{1'b0, 32'h3FC, 32'h0,        32'hA5A5A5A5, 1'b0, 16'h1234};
    vecs[6]  = '{1'b1, 32'h006, 32'hCAFEF00D, 32'hA5A5A5A5, TRAP, 16'h1234};
    vecs[7]  = '{1'b0, 32'h008, 32'h0,        32'hDEADBEEF, 1'b0, 16'h1234};
    vecs[8]  = '{1'b0, 32'h005, 32'h0,        prev_rd,      TRAP, 16'h1234};
    vecs[9]  = '{1'b0, 32'h004, 32'h0,        prev_rd,      1'b0, 16'h1234};
    vecs[10] = '{1'b1, 32'h00C, 32'h22222222, prev_rd,      1'b0, 16'h1234};
    vecs[11] = '{1'b0, 32'h00C, 32'h0,        32'h22222222, 1'b0, 16'h1234};

    rst = 1'b1;
    req = 1'b0; we = 1'b0; a = '0; wd = '0;
    req0 = 1'b0; we0 = 1'b0; a0 = '0; wd0 = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset/ack",   {31'b0, ack},   32'd0);
    checkOutput("reset/stall", {31'b0, stall}, 32'd0);
    checkOutput("reset/err",   {31'b0, err},   32'd0);
    checkOutput("reset/rd",    rd,             32'd0);
    checkOutput("reset/tv",    {16'b0, tv},    32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Req held through RESP: second access accepted only in the next IDLE.
    @(negedge clk);
    req = 1'b1; we = 1'b1; a = 32'h10; wd = 32'h77;
    #1;
    checkOutput("hold/stall_accept", {31'b0, stall}, 32'd1);
    @(negedge clk);
    wd = 32'hBAD;
    #1;
    checkOutput("hold/k1_stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    #1;
    checkOutput("hold/k2_ack", {31'b0, ack}, 32'd0);
    @(negedge clk);
    we = 1'b0;
    #1;
    checkOutput("hold/k3_ack",   {31'b0, ack},   32'd1);
    checkOutput("hold/k3_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("hold/k4_ack",   {31'b0, ack},   32'd0);
    checkOutput("hold/k4_stall", {31'b0, stall}, 32'd1);
    for (int k = 5; k <= 7; k++) begin
      @(negedge clk);
      req = 1'b0;
      #1;
      checkOutput($sformatf("hold/k%0d_ack", k), {31'b0, ack}, (k == 7) ? 32'd1 : 32'd0);
    end
    checkOutput("hold/rd_first_wd", rd, 32'h00000077);

    // Reset pulse while a store sits in WAIT.
    @(negedge clk);
    req = 1'b1; we = 1'b1; a = 32'h4; wd = 32'h5555AAAA;
    @(negedge clk);
    req = 1'b0;
    #1;
    checkOutput("rstwait/stall_wait", {31'b0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rstwait/stall", {31'b0, stall}, 32'd0);
    checkOutput("rstwait/rd",    rd,             32'd0);
    checkOutput("rstwait/tv",    {16'b0, tv},    32'd0);
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (ack) acks++;
    end
    checkOutput("rstwait/no_ack", acks, 32'd0);
    applyStimulus('{1'b0, 32'h4, 32'h0, 32'h0, 1'b0, 16'h0}, "rstwait_load");

    // Zero wait states: Ack one cycle after acceptance, single Stall cycle.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; a0 = 32'h0; wd0 = 32'h1357BEEF;
    #1;
    checkOutput("w0/store_stall", {31'b0, stall0}, 32'd1);
    checkOutput("w0/store_noack", {31'b0, ack0},   32'd0);
    @(negedge clk);
    req0 = 1'b0;
    #1;
    checkOutput("w0/store_ack",   {31'b0, ack0},   32'd1);
    checkOutput("w0/store_stall0", {31'b0, stall0}, 32'd0);
    checkOutput("w0/test_value",  {16'b0, tv0},    32'h0000BEEF);
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0;
    #1;
    checkOutput("w0/load_stall", {31'b0, stall0}, 32'd1);
    @(negedge clk);
    req0 = 1'b0;
    #1;
    checkOutput("w0/load_ack", {31'b0, ack0}, 32'd1);
    checkOutput("w0/load_rd",  rd0,           32'h1357BEEF);
    checkOutput("w0/load_err", {31'b0, err0}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("w0/ack_single", {31'b0, ack0},   32'd0);
    checkOutput("w0/idle_stall", {31'b0, stall0}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
